// File: rtl/systolic_pkg.sv
// Shared definitions for the N x N systolic matrix-multiply block:
// controller state encoding and drain/latency helpers.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEFAULT_N = 4;

  // Cycles the wavefront needs to reach PE(N-1,N-1) after the final beat.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  // Edges from accepting the final beat to out_valid rising.
  function automatic int out_latency(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/pe_acc.sv
// Multiply-accumulate processing element: fixed-point product added to a
// local accumulator, operands forwarded east (a) and south (b) one hop per cycle.
module pe_acc #(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic [BIT_WIDTH-1:0] i_a,
  input  logic [BIT_WIDTH-1:0] i_b,
  output logic [BIT_WIDTH-1:0] o_a,
  output logic [BIT_WIDTH-1:0] o_b,
  output logic [BIT_WIDTH-1:0] o_acc
);

  logic signed [2*BIT_WIDTH-1:0] w_prod;
  logic        [BIT_WIDTH-1:0]   w_term;
  logic        [BIT_WIDTH-1:0]   w_base;
  logic        [BIT_WIDTH-1:0]   r_a;
  logic        [BIT_WIDTH-1:0]   r_b;
  logic        [BIT_WIDTH-1:0]   r_acc;

  assign w_prod = $signed(i_a) * $signed(i_b);
  // Truncating to BIT_WIDTH after the arithmetic shift gives two's-complement wrap.
  assign w_term = BIT_WIDTH'(w_prod >>> FRAC_WIDTH);
  // Clear replaces the old sum so the current product becomes the first term.
  assign w_base = i_clear ? '0 : r_acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= w_base + w_term;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic array: skews unskewed A columns / B rows,
// accumulates C = A*B in pe_acc tiles, drains, and holds the product for handoff.
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*BIT_WIDTH-1:0]     west_in,
  input  logic [N*BIT_WIDTH-1:0]     north_in,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [N*N*BIT_WIDTH-1:0]   result,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int DRAIN_LEN = drain_cycles(N);
  localparam int CNT_W     = $clog2(DRAIN_LEN + 1);

  state_t                       r_state;
  logic                         r_in_ready;
  logic                         r_out_valid;
  logic [CNT_W-1:0]             r_cnt;
  logic [N*N*BIT_WIDTH-1:0]     r_result;

  logic                         w_accept;
  logic                         w_clear;
  logic [BIT_WIDTH-1:0]         w_a [N][N+1];
  logic [BIT_WIDTH-1:0]         w_b [N+1][N];
  logic [N*N*BIT_WIDTH-1:0]     w_acc;

  assign w_accept = in_valid && r_in_ready;
  assign w_clear  = w_accept && (r_state == IDLE);

  // Input skew: lane i is delayed i cycles; idle cycles inject zero bubbles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [BIT_WIDTH-1:0] w_lane_a;
    logic [BIT_WIDTH-1:0] w_lane_b;

    assign w_lane_a = w_accept ? west_in[i*BIT_WIDTH +: BIT_WIDTH]  : '0;
    assign w_lane_b = w_accept ? north_in[i*BIT_WIDTH +: BIT_WIDTH] : '0;

    if (i == 0) begin : g_direct
      assign w_a[0][0] = w_lane_a;
      assign w_b[0][0] = w_lane_b;
    end else begin : g_skew
      logic [BIT_WIDTH-1:0] r_ska [0:i-1];
      logic [BIT_WIDTH-1:0] r_skb [0:i-1];

      // NOTE: the delay lines are small register arrays, not RAM, so they are
      // reset; stale operands would otherwise leak into the next product.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            r_ska[s] <= '0;
            r_skb[s] <= '0;
          end
        end else begin
          r_ska[0] <= w_lane_a;
          r_skb[0] <= w_lane_b;
          for (int s = 1; s < i; s++) begin
            r_ska[s] <= r_ska[s-1];
            r_skb[s] <= r_skb[s-1];
          end
        end
      end

      assign w_a[i][0] = r_ska[i-1];
      assign w_b[0][i] = r_skb[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      pe_acc #(
        .BIT_WIDTH  (BIT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_a     (w_a[i][j]),
        .i_b     (w_b[i][j]),
        .o_a     (w_a[i][j+1]),
        .o_b     (w_b[i+1][j]),
        .o_acc   (w_acc[(i*N+j)*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  end

  // Controller: the counter covers the skew flight time plus one settle cycle
  // before the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            if (in_last) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
              r_cnt      <= CNT_W'(DRAIN_LEN);
            end else begin
              r_state    <= LOAD;
            end
          end
        end
        DRAIN: begin
          if (r_cnt == '0) begin
            r_result    <= w_acc;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: doc/systolic_array_nxn.md
SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001 SHALL have parameter N, default 4: array dimension (N x N PEs), legal 2..8.
REQ-002 SHALL have parameter BIT_WIDTH, default 16: signed fixed-point operand/result width.
REQ-003 SHALL have parameter FRAC_WIDTH, default 8: fractional bits, legal 0..BIT_WIDTH-1.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port west_in  input  N*BIT_WIDTH: A column vector; lane i (bits [i*BIT_WIDTH +: BIT_WIDTH]) feeds row i.
REQ-007 SHALL have port north_in  input  N*BIT_WIDTH: B row vector; lane j feeds column j.
REQ-008 SHALL have port in_valid  input  1: west_in/north_in hold one k-step beat.
REQ-009 SHALL have port in_last  input  1: qualifies the final beat of the block product; sampled only with in_valid.
REQ-010 SHALL have port in_ready  output  1: block accepts beats.
REQ-011 SHALL have port result  output  N*N*BIT_WIDTH: C[i][j] at bits [(i*N+j)*BIT_WIDTH +: BIT_WIDTH].
REQ-012 SHALL have port out_valid  output  1: result holds a complete product.
REQ-013 SHALL have port out_ready  input  1: consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DRAIN, HOLD.
REQ-015 SHALL move IDLE->LOAD on the first accepted beat, clearing all PE accumulators in that same cycle so the first beat's product is the first term accumulated.
REQ-016 SHALL accept a beat when in_valid && in_ready; in_ready SHALL be 1 in IDLE and LOAD, 0 in DRAIN and HOLD.
REQ-017 SHALL move to DRAIN on the cycle an accepted beat has in_last=1; a single beat with in_last=1 from IDLE goes IDLE->DRAIN directly (k=1).
REQ-018 SHALL skew inputs internally: row i delayed i cycles, column j delayed j cycles; the user presents unskewed vectors.
REQ-019 SHALL inject zero into the skew lines in any cycle without an accepted beat, so in_valid gaps are bubbles that do not corrupt the sum.
REQ-020 SHALL have each PE compute acc <= acc + ((a*b) >>> FRAC_WIDTH): full 2*BIT_WIDTH signed product, arithmetic shift, truncation to BIT_WIDTH, two's-complement wrap, no saturation.
REQ-021 SHALL have each PE register a east and b south, one cycle per hop.
REQ-022 SHALL remain in DRAIN for 2N-1 cycles via a down-counter, then register all accumulators into result and enter HOLD; out_valid SHALL rise exactly 2N cycles after the edge accepting the in_last beat (N=4: 8 cycles).
REQ-023 SHALL hold result and out_valid stable in HOLD until out_ready=1, then return to IDLE with out_valid=0 on the next cycle.
REQ-024 SHALL keep result unchanged outside HOLD until the next capture; out_valid=1 only in HOLD.
REQ-025 SHALL impose no upper bound on beats per product; accumulators wrap per REQ-020.

Reset
REQ-026 SHALL on rst=1 at a clock edge force state IDLE, in_ready=1 on the following cycle, out_valid=0, result=0, all accumulators, skew registers, PE pipeline registers and drain counter to 0.
REQ-027 SHALL give rst priority over every concurrent event, including an accepted beat or out_ready handshake in the same cycle; a product in progress is discarded.

Structure
REQ-028 SHALL place FSM state encoding and helper localparams for drain length (2N-1) and latency (2N) in shared package systolic_pkg.
REQ-029 SHALL use one sub-module pe_acc (MAC PE with clear and east/south pass-through), instantiated N*N via generate; skew lines and FSM live in the top module.

Verification
REQ-030 SHALL verify: N=4, FRAC_WIDTH=8, A=identity (0x0100 diag), B[k][j]=(k*4+j)*0x0100, 4 beats, in_last on beat 4 -> result equals B; out_valid exactly 8 cycles after last beat accepted.
REQ-031 SHALL verify: k=1 single beat with in_last, west=all 0x0200, north=all 0x0300 -> every C = 0x0600; IDLE->DRAIN direct.
REQ-032 SHALL verify: same 4-beat product with in_valid low 2 cycles between each beat -> identical result to REQ-030.
REQ-033 SHALL verify: out_ready held low 10 cycles in HOLD -> result/out_valid stable, in_ready=0, extra beats ignored; then one-cycle out_ready -> IDLE.
REQ-034 SHALL verify: rst pulsed during DRAIN of a product, then a k=1 product of 0x0100*0x0100 -> no out_valid from aborted product, new result all 0x0100.
REQ-035 SHALL verify: 0x7F00*0x7F00 accumulated 2 beats -> each C equals the REQ-020 wrapped value computed by the reference model (no saturation).
